// File: rtl/bit_arbiter_pkg.sv
// Shared types for the bit-RAM arbiters: thread index width, return tag layout.
// Used by bit_read_arbiter and bit_arb_pick.
package bit_arbiter_pkg;

    localparam int BIT_ADDR_W  = 16;
    localparam int MAX_THREADS = 16;

    function automatic int thread_idx_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    localparam int THREAD_IDX_W = thread_idx_w(MAX_THREADS);

    typedef logic [THREAD_IDX_W-1:0] thread_idx_t;

    // One slot of the return pipeline: which thread owns the RAM read in flight.
    typedef struct packed {
        logic        valid;
        thread_idx_t idx;
    } tag_t;

endpackage

// File: rtl/bit_arb_pick.sv
// Combinational grant picker over a request vector.
// BITREADARBITER_RR_EN selects round-robin from last+1; otherwise lowest index wins.
module bit_arb_pick
    import bit_arbiter_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0] req,
    input  thread_idx_t  last,
    output logic         gnt_valid,
    output thread_idx_t  gnt_idx,
    output logic [N-1:0] gnt_hot
);

`ifdef BITREADARBITER_RR_EN
    logic        hi_found;
    thread_idx_t hi_idx;
    logic        lo_found;
    thread_idx_t lo_idx;

    // Two passes: requesters above the last grant first, then wrap to the bottom.
    always_comb begin
        hi_found = 1'b0;
        hi_idx   = '0;
        lo_found = 1'b0;
        lo_idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i] && (i > int'(last))) begin
                hi_found = 1'b1;
                hi_idx   = thread_idx_t'(i);
            end
            if (req[i]) begin
                lo_found = 1'b1;
                lo_idx   = thread_idx_t'(i);
            end
        end
        gnt_valid = hi_found | lo_found;
        gnt_idx   = hi_found ? hi_idx : lo_idx;
    end
`else
    logic unused_last;
    assign unused_last = ^last;

    always_comb begin
        // NOTE: every output gets a default before the loop, so no path through
        // this block leaves a variable unassigned and no latch is inferred.
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                gnt_valid = 1'b1;
                gnt_idx   = thread_idx_t'(i);
            end
        end
    end
`endif

    always_comb begin
        gnt_hot = '0;
        for (int i = 0; i < N; i++) begin
            gnt_hot[i] = gnt_valid && (gnt_idx == thread_idx_t'(i));
        end
    end

endmodule

// File: rtl/bit_read_arbiter.sv
// Arbitrates single-bit reads from N threads onto one bit-RAM read port and routes
// each returned bit back with a one-cycle ACK. BITREADARBITER_RR_EN enables round-robin.
module bit_read_arbiter
    import bit_arbiter_pkg::*;
#(
    parameter int N_THREADS = 4,
    parameter int ADDR_W    = BIT_ADDR_W,
    parameter int RAM_LAT   = 1
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic                          BITREADARBITER_EN,
    input  logic                          BITREADARBITER_BIT_SELECT,
    input  logic [N_THREADS-1:0]          BITREADARBITER_THREAD_RE,
    input  logic [N_THREADS*ADDR_W-1:0]   BITREADARBITER_THREAD_ADDR,
    output logic                          BITREADARBITER_RAM_RE,
    output logic [ADDR_W-1:0]             BITREADARBITER_RAM_ADDR,
    input  logic                          BITREADARBITER_RAM_DATA,
    output logic                          BITREADARBITER_THREAD_DATA,
    output logic [N_THREADS-1:0]          BITREADARBITER_ACK,
    output logic                          BITREADARBITER_BUSY
);

    logic [N_THREADS-1:0] pending;
    logic [N_THREADS-1:0] inflight;
    logic [N_THREADS-1:0] sample;
    logic [N_THREADS-1:0] gnt_hot;
    logic [N_THREADS-1:0] gnt_taken;
    logic [N_THREADS-1:0] ret_hot;
    logic [N_THREADS-1:0] pending_nxt;
    logic [N_THREADS-1:0] inflight_nxt;
    logic                 gnt_valid;
    logic                 gnt_fire;
    thread_idx_t          gnt_idx;
    thread_idx_t          last_gnt;
    thread_idx_t          issue_tag;
    logic [ADDR_W-1:0]    gnt_addr;
    tag_t                 tag_pipe [RAM_LAT];
    tag_t                 ret_tag;

`ifdef BITREADARBITER_RR_EN
    thread_idx_t rr_ptr;

    always_ff @(posedge CLK) begin
        if (RST) begin
            rr_ptr <= '0;
        end else if (gnt_fire) begin
            rr_ptr <= gnt_idx;
        end
    end

    assign last_gnt = rr_ptr;
`else
    assign last_gnt = '0;
`endif

    bit_arb_pick #(
        .N (N_THREADS)
    ) u_pick (
        .req       (pending),
        .last      (last_gnt),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx),
        .gnt_hot   (gnt_hot)
    );

    assign gnt_fire  = BITREADARBITER_BIT_SELECT & gnt_valid;
    assign gnt_taken = {N_THREADS{gnt_fire}} & gnt_hot;
    assign ret_tag   = tag_pipe[RAM_LAT-1];

    // A thread is re-sampled only once both pending and inflight are clear, which
    // enforces one outstanding read per thread.
    always_comb begin
        sample   = '0;
        ret_hot  = '0;
        gnt_addr = '0;
        for (int i = 0; i < N_THREADS; i++) begin
            sample[i]  = BITREADARBITER_BIT_SELECT & BITREADARBITER_EN &
                         BITREADARBITER_THREAD_RE[i] & ~pending[i] & ~inflight[i];
            ret_hot[i] = ret_tag.valid && (ret_tag.idx == thread_idx_t'(i));
            if (gnt_hot[i]) begin
                gnt_addr = gnt_addr | BITREADARBITER_THREAD_ADDR[i*ADDR_W +: ADDR_W];
            end
        end
        pending_nxt  = (pending | sample) & ~gnt_taken;
        inflight_nxt = (inflight | gnt_taken) & ~ret_hot;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            pending                    <= '0;
            inflight                   <= '0;
            issue_tag                  <= '0;
            BITREADARBITER_RAM_RE      <= 1'b0;
            BITREADARBITER_RAM_ADDR    <= '0;
            BITREADARBITER_THREAD_DATA <= 1'b0;
            BITREADARBITER_ACK         <= '0;
            BITREADARBITER_BUSY        <= 1'b0;
            // NOTE: the tag pipeline is cleared on reset even though it is an array,
            // because its valid bits alone decide whether an ACK fires; stale tags
            // would otherwise acknowledge reads that reset discarded.
            for (int k = 0; k < RAM_LAT; k++) begin
                tag_pipe[k] <= '0;
            end
        end else begin
            // NOTE: non-blocking throughout, so every stage samples its pre-edge
            // neighbour; the tag shift below depends on that ordering.
            pending             <= pending_nxt;
            inflight            <= inflight_nxt;
            BITREADARBITER_BUSY <= (|pending_nxt) | (|inflight_nxt);

            BITREADARBITER_RAM_RE <= gnt_fire;
            if (gnt_fire) begin
                BITREADARBITER_RAM_ADDR <= gnt_addr;
                issue_tag               <= gnt_idx;
            end

            // The tag follows the registered strobe, so the tail of the pipe lines
            // up with the edge at which RAM_DATA becomes valid.
            tag_pipe[0].valid <= BITREADARBITER_RAM_RE;
            tag_pipe[0].idx   <= issue_tag;
            for (int k = 1; k < RAM_LAT; k++) begin
                tag_pipe[k] <= tag_pipe[k-1];
            end

            BITREADARBITER_ACK <= ret_hot;
            if (ret_tag.valid) begin
                BITREADARBITER_THREAD_DATA <= BITREADARBITER_RAM_DATA;
            end
        end
    end

endmodule

// File: tb/tb_bit_read_arbiter.sv
// Self-checking bench: two arbiters (RAM_LAT=1 and RAM_LAT=3) share one stimulus;
// each has its own RAM model and scoreboard of expected ACK thread/data/edge.
module tb_bit_read_arbiter;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        EN  = 1'b1;
    logic        BS  = 1'b1;
    logic [3:0]  RE  = '0;
    logic [15:0] ta [4];
    logic [63:0] taddr;

    logic        re1, re3;
    logic [15:0] ra1, ra3;
    logic        td1, td3;
    logic [3:0]  ack1, ack3;
    logic        busy1, busy3;
    bit          rd1;
    bit          rd3 [3];

    typedef struct {
        int   thread;
        logic data;
        int   cyc;
    } exp_t;

    exp_t q [2][$];
    int   cyc   = 0;
    int   n_vec = 0;
    int   n_err = 0;
    bit   ram_bits [65536];

    assign taddr = {ta[3], ta[2], ta[1], ta[0]};

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    bit_read_arbiter #(.N_THREADS(4), .ADDR_W(16), .RAM_LAT(1)) u_l1 (
        .CLK                        (CLK),
        .RST                        (RST),
        .BITREADARBITER_EN          (EN),
        .BITREADARBITER_BIT_SELECT  (BS),
        .BITREADARBITER_THREAD_RE   (RE),
        .BITREADARBITER_THREAD_ADDR (taddr),
        .BITREADARBITER_RAM_RE      (re1),
        .BITREADARBITER_RAM_ADDR    (ra1),
        .BITREADARBITER_RAM_DATA    (rd1),
        .BITREADARBITER_THREAD_DATA (td1),
        .BITREADARBITER_ACK         (ack1),
        .BITREADARBITER_BUSY        (busy1)
    );

    bit_read_arbiter #(.N_THREADS(4), .ADDR_W(16), .RAM_LAT(3)) u_l3 (
        .CLK                        (CLK),
        .RST                        (RST),
        .BITREADARBITER_EN          (EN),
        .BITREADARBITER_BIT_SELECT  (BS),
        .BITREADARBITER_THREAD_RE   (RE),
        .BITREADARBITER_THREAD_ADDR (taddr),
        .BITREADARBITER_RAM_RE      (re3),
        .BITREADARBITER_RAM_ADDR    (ra3),
        .BITREADARBITER_RAM_DATA    (rd3[2]),
        .BITREADARBITER_THREAD_DATA (td3),
        .BITREADARBITER_ACK         (ack3),
        .BITREADARBITER_BUSY        (busy3)
    );

    // RAM models: data valid RAM_LAT edges after the strobe/address register.
    always @(posedge CLK) begin
        if (re1) rd1 <= ram_bits[ra1];
        rd3[0] <= ram_bits[ra3];
        rd3[1] <= rd3[0];
        rd3[2] <= rd3[1];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic mon(input int n, input logic [3:0] ack, input logic data, input string tag);
        exp_t e;
        if (ack !== 4'b0000) begin
            if (q[n].size() == 0) begin
                chk({tag, "_unexpected_ack"}, {28'd0, ack}, 32'd0);
            end else begin
                e = q[n].pop_front();
                chk({tag, "_ack_hot"},   {28'd0, ack}, 32'd1 << e.thread);
                chk({tag, "_ack_data"},  {31'd0, data}, {31'd0, e.data});
                chk({tag, "_ack_cycle"}, cyc, e.cyc);
            end
        end else if (q[n].size() != 0 && q[n][0].cyc < cyc) begin
            e = q[n].pop_front();
            chk({tag, "_ack_missing"}, {28'd0, ack}, 32'd1 << e.thread);
        end
    endtask

    always @(negedge CLK) begin
        mon(0, ack1, td1, "l1");
        mon(1, ack3, td3, "l3");
    end

    task automatic tick();
        @(negedge CLK);
    endtask

    task automatic set_addr(input int t, input logic [15:0] a, input bit v);
        ta[t]       = a;
        ram_bits[a] = v;
    endtask

    task automatic push_one(input int n, input int t, input int c);
        exp_t e;
        e.thread = t;
        e.data   = ram_bits[ta[t]];
        e.cyc    = c;
        q[n].push_back(e);
    endtask

    // off is the ACK edge minus RAM_LAT.
    task automatic push_rd(input int t, input int off);
        push_one(0, t, off + 1);
        push_one(1, t, off + 3);
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 60; i++) begin
            if (q[0].size() == 0 && q[1].size() == 0) break;
            tick();
        end
        chk({tag, "_drain"}, q[0].size() + q[1].size(), 32'd0);
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_ram_re"},  {30'd0, re1, re3}, 32'd0);
        chk({tag, "_ram_addr"}, {ra1, ra3}, 32'd0);
        chk({tag, "_data"},    {30'd0, td1, td3}, 32'd0);
        chk({tag, "_ack"},     {24'd0, ack1, ack3}, 32'd0);
        chk({tag, "_busy"},    {30'd0, busy1, busy3}, 32'd0);
    endtask

    initial begin
        int e0;
        int p;
        int s;
        for (int t = 0; t < 4; t++) ta[t] = '0;

        // Reset state
        tick();
        tick();
        check_idle("reset");
        RST = 1'b0;

        // Single read, thread 2
        set_addr(2, 16'h0A5C, 1'b1);
        RE = 4'b0100;
        e0 = cyc + 1;
        push_rd(2, e0 + 2);
        tick();
        RE = 4'b0000;
        chk("single_no_re_yet", {30'd0, re1, re3}, 32'd0);
        chk("single_busy", {30'd0, busy1, busy3}, 32'h3);
        tick();
        chk("single_ram_re", {30'd0, re1, re3}, 32'h3);
        chk("single_ram_addr", {ra1, ra3}, {16'h0A5C, 16'h0A5C});
        wait_drain("single");
        chk("single_busy_clear", {30'd0, busy1, busy3}, 32'd0);

        // Contention: fixed order 0,1,3 from one sampling edge
        set_addr(0, 16'h0100, 1'b1);
        set_addr(1, 16'h0101, 1'b0);
        set_addr(3, 16'h0103, 1'b1);
        RE = 4'b1011;
        e0 = cyc + 1;
        push_rd(0, e0 + 2);
        push_rd(1, e0 + 3);
        push_rd(3, e0 + 4);
        tick();
        RE = 4'b0000;
        wait_drain("contend");

        // All threads hold RE for 12 sampling edges
        set_addr(0, 16'h0200, 1'b1);
        set_addr(1, 16'h0201, 1'b0);
        set_addr(2, 16'h0202, 1'b0);
        set_addr(3, 16'h0203, 1'b1);
        RE = 4'b1111;
        e0 = cyc + 1;
        for (int n = 0; n < 2; n++) begin
            p = (n == 0) ? 1 : 3;
            for (int k = 0; k < 6; k++) begin
                for (int i = 0; i < 4; i++) begin
                    s = (k == 0) ? e0 : e0 + i + k * (3 + p);
                    if (s <= e0 + 11) push_one(n, i, e0 + 2 + p + i + k * (3 + p));
                end
            end
        end
        repeat (12) tick();
        RE = 4'b0000;
        wait_drain("hold_all");

        // BIT_SELECT low for three edges after two grants
        set_addr(0, 16'h0300, 1'b0);
        set_addr(1, 16'h0301, 1'b1);
        set_addr(2, 16'h0302, 1'b1);
        set_addr(3, 16'h0303, 1'b0);
        RE = 4'b1111;
        e0 = cyc + 1;
        push_rd(0, e0 + 2);
        push_rd(1, e0 + 3);
        push_rd(2, e0 + 7);
        push_rd(3, e0 + 8);
        tick();
        RE = 4'b0000;
        tick();
        tick();
        BS = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_no_ram_re", {30'd0, re1, re3}, 32'd0);
        end
        BS = 1'b1;
        tick();
        chk("stall_resume_re", {30'd0, re1, re3}, 32'h3);
        chk("stall_resume_addr", {ra1, ra3}, {16'h0302, 16'h0302});
        wait_drain("stall");

        // EN low: pending reads still served, new requests ignored
        set_addr(0, 16'h0500, 1'b1);
        set_addr(2, 16'h0502, 1'b1);
        RE = 4'b0101;
        e0 = cyc + 1;
        push_rd(0, e0 + 2);
        push_rd(2, e0 + 3);
        tick();
        EN = 1'b0;
        RE = 4'b1111;
        repeat (3) tick();
        wait_drain("en_low");
        chk("en_low_busy", {30'd0, busy1, busy3}, 32'd0);
        chk("en_low_ram_re", {30'd0, re1, re3}, 32'd0);
        RE = 4'b0000;
        tick();
        EN = 1'b1;

        // Reset with two reads in flight
        set_addr(0, 16'h0400, 1'b1);
        set_addr(1, 16'h0401, 1'b1);
        RE = 4'b0011;
        tick();
        RE = 4'b0000;
        tick();
        tick();
        RST = 1'b1;
        tick();
        check_idle("mid_reset");
        RST = 1'b0;
        repeat (6) tick();
        RE = 4'b0010;
        e0 = cyc + 1;
        push_rd(1, e0 + 2);
        tick();
        RE = 4'b0000;
        wait_drain("after_reset");

        tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
